// File: rtl/mod_multiplicador_sec.sv
// mod_multiplicador_sec: sequential signed shift-add multiplier, WIDTH-bit result with overflow flag.
// Optional macro MULT_SAT_EN saturates M on overflow instead of wrapping.
`default_nettype none

module mod_multiplicador_sec #(
    parameter int WIDTH = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] M,
    output logic             OF_MUL,
    output logic             BUSY,
    output logic             VALID
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, state_nx;
    logic [2*WIDTH-1:0]   acc, mcand, acc_nx, prod;
    logic [WIDTH-1:0]     mplier, abs_a, abs_b, res;
    logic [CW-1:0]        cnt;
    logic                 sgn, accept, last, ovf;

    assign abs_a  = A[WIDTH-1] ? (~A + 1'b1) : A;
    assign abs_b  = B[WIDTH-1] ? (~B + 1'b1) : B;
    assign accept = START && (state != CALC);
    assign last   = (cnt == '0);
    assign BUSY   = (state == CALC);
    assign VALID  = (state == DONE);

    // Final iteration is folded into the result so M lands on the last CALC edge.
    assign acc_nx = acc + (mplier[0] ? mcand : '0);
    assign prod   = sgn ? (~acc_nx + 1'b1) : acc_nx;
    assign ovf    = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));

`ifdef MULT_SAT_EN
    assign res = ovf ? (sgn ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                     : prod[WIDTH-1:0];
`else
    assign res = prod[WIDTH-1:0];
`endif

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (START) state_nx = CALC;
            CALC:    if (last)  state_nx = DONE;
            DONE:    state_nx = START ? CALC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            sgn    <= 1'b0;
            M      <= '0;
            OF_MUL <= 1'b0;
        end else if (accept) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, abs_a};
            mplier <= abs_b;
            sgn    <= A[WIDTH-1] ^ B[WIDTH-1];
            cnt    <= CW'(WIDTH - 1);
        end else if (state == CALC) begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
            if (last) begin
                M      <= res;
                OF_MUL <= ovf;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mod_multiplicador_sec.sv
// Self-checking bench for mod_multiplicador_sec (WIDTH=6): vector table, corner sequences, random ops.
`default_nettype none

module tb_mod_multiplicador_sec;

    localparam int W = 6;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         START = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] M;
    logic         OF_MUL, BUSY, VALID;

    int errors = 0;
    int checks = 0;

    mod_multiplicador_sec #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
        .M(M), .OF_MUL(OF_MUL), .BUSY(BUSY), .VALID(VALID)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int a;
        int b;
        int m_wrap;
        int m_sat;
        int of;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sm();
        return int'($signed(M));
    endfunction

    // Reference: exact integer product, then range test and wrap/saturate.
    function automatic void model(input int a, input int b, output int m, output int of);
        int p, lo, maxv, minv;
        p    = a * b;
        maxv = 2**(W-1) - 1;
        minv = -(2**(W-1));
        of   = (p > maxv || p < minv) ? 1 : 0;
`ifdef MULT_SAT_EN
        m = of ? ((p > 0) ? maxv : minv) : p;
`else
        lo = p & (2**W - 1);
        m  = (lo >= 2**(W-1)) ? lo - 2**W : lo;
`endif
    endfunction

    // Called at the negedge n0 cycles after the accepting edge; returns at the VALID negedge.
    task automatic wait_result(input string tag, input int n0, input int em, input int eof);
        int n;
        n = n0;
        while (BUSY && n < 4*W) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, " busy_cycles"}, n, W);
        chk({tag, " valid"}, int'(VALID), 1);
        chk({tag, " m"}, sm(), em);
        chk({tag, " of"}, int'(OF_MUL), eof);
    endtask

    task automatic do_op(input string tag, input int a, input int b, input int em, input int eof);
        @(negedge CLK);
        A = W'(a);
        B = W'(b);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        chk({tag, " busy_start"}, int'(BUSY), 1);
        wait_result(tag, 0, em, eof);
        @(negedge CLK);
        chk({tag, " valid_drop"}, int'(VALID), 0);
        chk({tag, " m_hold"}, sm(), em);
    endtask

    initial begin
        int em, eof, n, ra, rb;
        logic [W-1:0] r;

        tbl[0]  = '{3, 5, 15, 15, 0};
        tbl[1]  = '{-4, 7, -28, -28, 0};
        tbl[2]  = '{-32, 1, -32, -32, 0};
        tbl[3]  = '{8, 8, 0, 31, 1};
        tbl[4]  = '{-32, -1, -32, 31, 1};
        tbl[5]  = '{0, -32, 0, 0, 0};
        tbl[6]  = '{-2, -3, 6, 6, 0};
        tbl[7]  = '{31, -1, -31, -31, 0};
        tbl[8]  = '{-32, -32, 0, 31, 1};
        tbl[9]  = '{5, -7, 29, -32, 1};
        tbl[10] = '{4, -8, -32, -32, 0};
        tbl[11] = '{-1, -1, 1, 1, 0};

        RST = 1'b1;
        repeat (2) @(negedge CLK);
        chk("reset m", sm(), 0);
        chk("reset of", int'(OF_MUL), 0);
        chk("reset busy", int'(BUSY), 0);
        chk("reset valid", int'(VALID), 0);
        RST = 1'b0;

        for (int i = 0; i < 12; i++) begin
`ifdef MULT_SAT_EN
            do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].m_sat, tbl[i].of);
`else
            do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].m_wrap, tbl[i].of);
`endif
        end

        // START during CALC is ignored; START held in DONE launches the next op.
        @(negedge CLK);
        A = 6'd3; B = 6'd5; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        A = 6'd7; B = 6'd7; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_result("ignore", 2, 15, 0);
        A = 6'd2; B = 6'd3; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("b2b busy_start", int'(BUSY), 1);
        wait_result("b2b", 0, 6, 0);

        // Make M nonzero, then abort an op with reset (START also high under reset).
        do_op("pre_abort", 7, 3, 21, 0);
        @(negedge CLK);
        A = 6'd7; B = 6'd3; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        START = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        START = 1'b0;
        chk("abort busy", int'(BUSY), 0);
        chk("abort m", sm(), 0);
        chk("abort of", int'(OF_MUL), 0);
        n = 0;
        for (int k = 0; k < 2*W; k++) begin
            if (VALID || BUSY) n++;
            @(negedge CLK);
        end
        chk("abort no_valid", n, 0);
        do_op("post_abort", -2, -3, 6, 0);

        for (int i = 0; i < 40; i++) begin
            r  = W'($urandom);
            ra = int'($signed(r));
            r  = W'($urandom);
            rb = int'($signed(r));
            model(ra, rb, em, eof);
            do_op($sformatf("rnd%0d(%0d*%0d)", i, ra, rb), ra, rb, em, eof);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
